// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
//   Instruction-fetch front end feeding the IF/ID pipeline register. It owns
//   the fetch PC, issues one word read per cycle to a synchronous instruction
//   ROM (fixed 1-cycle latency), queues the returned {pc, pc+4, instr} tuples
//   in a small FIFO and hands them to decode. A redirect flushes the FIFO and
//   drops any read still in flight, then refetches from the new target.
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_reset        synchronous, active-low reset
//   o_imem_req     ROM read request this cycle
//   o_imem_addr    word-aligned ROM read address (the fetch PC)
//   i_imem_rdata   ROM read data, valid the cycle after a request
//   i_redirect     flush and refetch (taken branch / jump)
//   i_redirect_pc  new fetch target (low two bits ignored)
//   o_valid        FIFO head is valid
//   o_pc           PC of head instruction (0 when empty)
//   o_pc_plus4     o_pc + 4 (0 when empty)
//   o_instr        head instruction word (0 when empty)
//   i_ready        decode accepts the head
//
// Handshake: the head transfers to decode in a cycle where o_valid=1 and
// i_ready=1 (and no redirect). o_valid never depends on i_ready, and while
// o_valid=1 and i_ready=0 the head fields hold stable.
// ---------------------------------------------------------------------------
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_instr,
    input  logic        i_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    // Fetch state
    logic [31:0]   r_fetch_pc;
    logic          r_inflight;
    logic [31:0]   r_inflight_pc;

    // FIFO state
    logic [31:0]   r_pc_mem    [DEPTH];
    logic [31:0]   r_instr_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [CW-1:0] w_credit_used;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_head_pc;
    logic [31:0]   w_head_instr;

    // A slot is reserved for the outstanding read, so an issue is only made
    // when the FIFO can absorb it even if decode pops nothing meanwhile.
    assign w_credit_used = r_count + {{(CW-1){1'b0}}, r_inflight};
    assign w_issue       = i_reset & ~i_redirect & (w_credit_used < CW'(DEPTH));

    // The read returning this cycle belongs to the old path on a redirect.
    assign w_push = r_inflight & ~i_redirect;
    assign w_pop  = o_valid & i_ready & ~i_redirect;

    assign o_imem_req  = w_issue;
    assign o_imem_addr = r_fetch_pc;

    assign w_head_pc    = r_pc_mem[r_rd_ptr];
    assign w_head_instr = r_instr_mem[r_rd_ptr];

    assign o_valid    = (r_count != '0);
    assign o_pc       = o_valid ? w_head_pc : 32'h0;
    assign o_pc_plus4 = o_valid ? (w_head_pc + 32'd4) : 32'h0;
    assign o_instr    = o_valid ? w_head_instr : 32'h0;

    // Fetch PC and in-flight tracking
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
        end else if (i_redirect) begin
            r_fetch_pc <= {i_redirect_pc[31:2], 2'b00};
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc    <= r_fetch_pc + 32'd4;
                r_inflight_pc <= r_fetch_pc;
            end
        end
    end

    // FIFO storage; contents are never read while empty, so no reset needed.
    always_ff @(posedge i_clk) begin
        if (i_reset && w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_inflight_pc;
            r_instr_mem[r_wr_ptr] <= i_imem_rdata;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk) begin
        if (!i_reset || i_redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

    localparam int DEPTH = 4;
    localparam logic [31:0] XMASK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic [31:0] o_instr;
    logic        i_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .o_pc          (o_pc),
        .o_pc_plus4    (o_pc_plus4),
        .o_instr       (o_instr),
        .i_ready       (i_ready)
    );

    // Synchronous ROM model, 1-cycle latency: word = addr ^ A5A5_0000
    logic [31:0] rom_q = 32'h0;
    always @(posedge clk) rom_q <= o_imem_addr ^ XMASK;
    assign i_imem_rdata = rom_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {31'b0, o_valid}, 32'd1);
        check({tag, "_pc"}, o_pc, pc);
        check({tag, "_pc4"}, o_pc_plus4, pc + 32'd4);
        check({tag, "_instr"}, o_instr, pc ^ XMASK);
    endtask

    // Reset then release; returns in cycle 0 after the release edge.
    task automatic apply_reset();
        i_reset    = 1'b0;
        i_redirect = 1'b0;
        step();
        step();
        i_reset = 1'b1;
    endtask

    // A push must never land on a full FIFO.
    always @(negedge clk) begin
        if (i_reset === 1'b1 && dut.r_inflight && !i_redirect) begin
            check("no_push_when_full", {31'b0, dut.r_count == DEPTH}, 32'd0);
        end
    end

    initial begin
        int n;
        i_reset       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        i_ready       = 1'b1;

        // Reset state
        step();
        sample();
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_req", {31'b0, o_imem_req}, 32'd0);
        check("rst_pc", o_pc, 32'h0);
        check("rst_pc4", o_pc_plus4, 32'h0);
        check("rst_instr", o_instr, 32'h0);

        // 1: streaming from reset with decode always ready
        apply_reset();
        sample();
        check("t1_c0_req", {31'b0, o_imem_req}, 32'd1);
        check("t1_c0_addr", o_imem_addr, 32'h0);
        check("t1_c0_valid", {31'b0, o_valid}, 32'd0);
        step(); sample();
        check("t1_c1_valid", {31'b0, o_valid}, 32'd0);
        check("t1_c1_addr", o_imem_addr, 32'h4);
        step(); sample();
        check_head("t1_c2", 32'h0);
        for (int k = 1; k <= 5; k++) begin
            step(); sample();
            check_head("t1_stream", 32'(4 * k));
        end

        // 2: decode stalled for 10 cycles, FIFO fills, then drains in order
        i_ready = 1'b0;
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            sample();
            if (c >= 2) check_head("t2_hold", 32'h0);
        end
        check("t2_full_req", {31'b0, o_imem_req}, 32'd0);
        check("t2_full_cnt", {28'b0, dut.r_count}, 32'd4);
        step();
        i_ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 30 && n < 6; cyc++) begin
            sample();
            if (o_valid) begin
                check("t2_drain_pc", o_pc, 32'(4 * n));
                check("t2_drain_instr", o_instr, 32'(4 * n) ^ XMASK);
                n++;
            end
            step();
        end
        check("t2_drain_count", n, 32'd6);

        // 3: redirect with 3 queued entries and 1 read in flight
        i_ready = 1'b0;
        apply_reset();
        step(); step(); step(); step();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h100;
        sample();
        check("t3_t_req", {31'b0, o_imem_req}, 32'd0);
        check("t3_t_valid", {31'b0, o_valid}, 32'd1);
        step();
        i_redirect = 1'b0;
        i_ready    = 1'b1;
        sample();
        check("t3_t1_valid", {31'b0, o_valid}, 32'd0);
        check("t3_t1_req", {31'b0, o_imem_req}, 32'd1);
        check("t3_t1_addr", o_imem_addr, 32'h100);
        step(); sample();
        check("t3_t2_valid", {31'b0, o_valid}, 32'd0);
        step(); sample();
        check_head("t3_t3", 32'h100);
        step(); sample();
        check_head("t3_t4", 32'h104);
        step(); sample();
        check_head("t3_t5", 32'h108);

        // 4: misaligned redirect target is forced to word alignment
        step();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h102;
        sample();
        check("t4_t_req", {31'b0, o_imem_req}, 32'd0);
        step();
        i_redirect = 1'b0;
        sample();
        check("t4_t1_req", {31'b0, o_imem_req}, 32'd1);
        check("t4_t1_addr", o_imem_addr, 32'h100);
        check("t4_t1_valid", {31'b0, o_valid}, 32'd0);
        step(); sample();
        check("t4_t2_valid", {31'b0, o_valid}, 32'd0);
        step(); sample();
        check_head("t4_t3", 32'h100);

        // 5: back-to-back redirects, only the latest target survives
        step();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h200;
        sample();
        check("t5_t_req", {31'b0, o_imem_req}, 32'd0);
        step();
        i_redirect_pc = 32'h300;
        sample();
        check("t5_t1_req", {31'b0, o_imem_req}, 32'd0);
        check("t5_t1_valid", {31'b0, o_valid}, 32'd0);
        step();
        i_redirect = 1'b0;
        sample();
        check("t5_t2_addr", o_imem_addr, 32'h300);
        check("t5_t2_valid", {31'b0, o_valid}, 32'd0);
        step(); sample();
        check("t5_t3_valid", {31'b0, o_valid}, 32'd0);
        step(); sample();
        check_head("t5_t4", 32'h300);
        step(); sample();
        check_head("t5_t5", 32'h304);

        // 6: reset together with redirect mid-stream; reset wins
        step();
        i_reset       = 1'b0;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h400;
        sample();
        check("t6_req", {31'b0, o_imem_req}, 32'd0);
        step();
        i_redirect = 1'b0;
        sample();
        check("t6_valid", {31'b0, o_valid}, 32'd0);
        check("t6_pc", o_pc, 32'h0);
        check("t6_pc4", o_pc_plus4, 32'h0);
        check("t6_instr", o_instr, 32'h0);
        check("t6_req_held", {31'b0, o_imem_req}, 32'd0);
        step();
        i_reset = 1'b1;
        sample();
        check("t6_rel_req", {31'b0, o_imem_req}, 32'd1);
        check("t6_rel_addr", o_imem_addr, 32'h0);
        step(); step(); sample();
        check_head("t6_restart", 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
